// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU/operand selects,
// branch one-hot positions, the ID/EX control bundle and the halt FSM states.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_ZERO   = 7'b0000000;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] FUNCT7_HALT   = 7'b0000001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_M     = 2'b11;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLT  = 2;
  localparam int BR_BGE  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BGEU = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       jal;
    logic       jalr;
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [5:0] branch;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Decode-stage bus. Handshake: an instruction moves from IF/ID into the stage on
// a rising edge where in_valid && in_ready && !flush; in_ready never depends on in_valid.
interface decode_ctrl_pipe_if #(parameter int CNT_W = 16);
  import rv32_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic             ex_illegal;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_jal;
  logic             ex_jalr;
  logic [1:0]       ex_alu_op;
  logic [1:0]       ex_alu_src_a;
  logic [1:0]       ex_alu_src_b;
  logic [5:0]       ex_branch;
  logic             halt;
  logic [CNT_W-1:0] illegal_count;
  state_t           dbg_state;

  modport master (
    output in_valid, instr, stall, flush,
    input  in_ready, ex_valid, ex_illegal, ex_reg_write, ex_mem_to_reg, ex_mem_read,
           ex_mem_write, ex_jal, ex_jalr, ex_alu_op, ex_alu_src_a, ex_alu_src_b,
           ex_branch, halt, illegal_count, dbg_state
  );

  modport slave (
    input  in_valid, instr, stall, flush,
    output in_ready, ex_valid, ex_illegal, ex_reg_write, ex_mem_to_reg, ex_mem_read,
           ex_mem_write, ex_jal, ex_jalr, ex_alu_op, ex_alu_src_a, ex_alu_src_b,
           ex_branch, halt, illegal_count, dbg_state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I instruction -> control bundle, with illegal and halt flags.
// Build option RV32M_EN: R-type funct7 0000001 decodes as an M-class ALU op.
module ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        halt_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr_i[6:0];
  assign funct3        = instr_i[14:12];
  assign funct7        = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    ctrl_o       = '0;
    ctrl_o.valid = 1'b1;
    halt_o       = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
          ctrl_o.alu_op    = ALU_M;
          ctrl_o.reg_write = 1'b1;
`else
          ctrl_o.illegal   = 1'b1;
`endif
        end else begin
          ctrl_o.alu_op    = ALU_FUNCT;
          ctrl_o.reg_write = 1'b1;
        end
      end
      OP_I: begin
        ctrl_o.alu_op    = ALU_FUNCT;
        ctrl_o.src_b     = SRCB_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.src_b      = SRCB_IMM;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.src_b     = SRCB_IMM;
        ctrl_o.mem_write = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.src_a     = SRCA_PC;
        ctrl_o.src_b     = SRCB_FOUR;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jal       = 1'b1;
      end
      OP_JALR: begin
        ctrl_o.src_a     = SRCA_PC;
        ctrl_o.src_b     = SRCB_FOUR;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jalr      = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.src_a     = SRCA_ZERO;
        ctrl_o.src_b     = SRCB_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_o.src_a     = SRCA_PC;
        ctrl_o.src_b     = SRCB_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.alu_op = ALU_BR;
        case (funct3)
          3'd0:    ctrl_o.branch[BR_BEQ]  = 1'b1;
          3'd1:    ctrl_o.branch[BR_BNE]  = 1'b1;
          3'd4:    ctrl_o.branch[BR_BLT]  = 1'b1;
          3'd5:    ctrl_o.branch[BR_BGE]  = 1'b1;
          3'd6:    ctrl_o.branch[BR_BLTU] = 1'b1;
          3'd7:    ctrl_o.branch[BR_BGEU] = 1'b1;
          default: begin
            ctrl_o.alu_op  = ALU_ADD;
            ctrl_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ZERO: ;
      // Every SYSTEM word is a NOP downstream; only the halt ecall has a side effect.
      OP_SYSTEM: halt_o = (funct3 == 3'd0) && (funct7 == FUNCT7_HALT);
      default:   ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered ID/EX decode stage: control register with flush/stall, illegal counter
// and the RUN/DRAIN/HALTED halt FSM. Build option RV32M_EN is handled in ctrl_decode.
module decode_ctrl_pipe
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_ctrl_pipe_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_t            dec_ctrl;
  logic             dec_halt;
  logic             in_ready;
  logic             accept;
  ctrl_t            ex_d, ex_q;
  logic [CNT_W-1:0] illegal_count_d, illegal_count_q;
  state_t           state_q;
  logic [DW-1:0]    drain_q;
  logic             halt_q;

  ctrl_decode u_decode (
    .instr_i (bus.instr),
    .ctrl_o  (dec_ctrl),
    .halt_o  (dec_halt)
  );

  assign in_ready = (state_q == ST_RUN) && !bus.stall;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Flush beats stall; anything not accepted or held becomes a bubble.
  always_comb begin
    ex_d = '0;
    if (bus.flush)       ex_d = '0;
    else if (bus.stall)  ex_d = ex_q;
    else if (accept)     ex_d = dec_ctrl;
  end

  always_comb begin
    illegal_count_d = illegal_count_q;
    if (accept && dec_ctrl.illegal && (illegal_count_q != {CNT_W{1'b1}}))
      illegal_count_d = illegal_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q            <= '0;
      illegal_count_q <= '0;
    end else begin
      ex_q            <= ex_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && dec_halt) begin
            state_q <= ST_DRAIN;
            drain_q <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        ST_HALTED: halt_q <= 1'b1;
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_jal        = ex_q.jal;
  assign bus.ex_jalr       = ex_q.jalr;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_src_a  = ex_q.src_a;
  assign bus.ex_alu_src_b  = ex_q.src_b;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.halt          = halt_q;
  assign bus.illegal_count = illegal_count_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe; follows RV32M_EN for the mul expectation.
module tb_decode_ctrl_pipe;
  import rv32_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int DRAIN = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   exp_cnt;

  decode_ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();

  decode_ctrl_pipe #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed ex_* bits: {valid,illegal,reg_write,mem_to_reg,mem_read,mem_write,jal,jalr,alu_op,src_a,src_b,branch}
  logic [19:0] ex_vec;
  assign ex_vec = {bus.ex_valid, bus.ex_illegal, bus.ex_reg_write, bus.ex_mem_to_reg,
                   bus.ex_mem_read, bus.ex_mem_write, bus.ex_jal, bus.ex_jalr,
                   bus.ex_alu_op, bus.ex_alu_src_a, bus.ex_alu_src_b, bus.ex_branch};

  function automatic logic [19:0] mk(input logic [7:0] flags, input logic [1:0] alu,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [5:0] br);
    return {flags, alu, sa, sb, br};
  endfunction

  localparam logic [19:0] EXP_ADD     = {8'b1010_0000, 2'b10, 2'b00, 2'b00, 6'b000000};
  localparam logic [19:0] EXP_ILLEGAL = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 6'b000000};

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bus.in_valid = v;
    bus.instr    = ins;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checks++;
    if (ex_vec !== 20'h0) begin
      fails++; $display("FAIL reset_ex: got %h expected %h", ex_vec, 20'h0);
    end
    checks++;
    if (bus.halt !== 1'b0) begin
      fails++; $display("FAIL reset_halt: got %b expected 0", bus.halt);
    end
    checks++;
    if (bus.illegal_count !== '0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", bus.illegal_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_decode_table();
    logic [31:0] ins [12];
    logic [19:0] exp [12];
    ins[0]  = 32'h003100B3; exp[0]  = EXP_ADD;
    ins[1]  = 32'h00108093; exp[1]  = mk(8'b1010_0000, 2'b10, 2'b00, 2'b01, 6'b0);
    ins[2]  = 32'h0000A103; exp[2]  = mk(8'b1011_1000, 2'b00, 2'b00, 2'b01, 6'b0);
    ins[3]  = 32'h0020A023; exp[3]  = mk(8'b1000_0100, 2'b00, 2'b00, 2'b01, 6'b0);
    ins[4]  = 32'h0080006F; exp[4]  = mk(8'b1010_0010, 2'b00, 2'b01, 2'b10, 6'b0);
    ins[5]  = 32'h000080E7; exp[5]  = mk(8'b1010_0001, 2'b00, 2'b01, 2'b10, 6'b0);
    ins[6]  = 32'h000010B7; exp[6]  = mk(8'b1010_0000, 2'b00, 2'b10, 2'b01, 6'b0);
    ins[7]  = 32'h00001097; exp[7]  = mk(8'b1010_0000, 2'b00, 2'b01, 2'b01, 6'b0);
    ins[8]  = 32'h40208033; exp[8]  = EXP_ADD;
    ins[9]  = 32'h00208463; exp[9]  = mk(8'b1000_0000, 2'b01, 2'b00, 2'b00, 6'b000001);
    ins[10] = 32'h0020E463; exp[10] = mk(8'b1000_0000, 2'b01, 2'b00, 2'b00, 6'b010000);
    ins[11] = 32'h0020A463; exp[11] = EXP_ILLEGAL;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ins[i], 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_vec !== exp[i]) begin
        fails++; $display("FAIL decode_%0d (%h): got %h expected %h", i, ins[i], ex_vec, exp[i]);
      end
    end
    exp_cnt = exp_cnt + 1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_vec !== 20'h0) begin
      fails++; $display("FAIL bubble_after_table: got %h expected 0", ex_vec);
    end
    checks++;
    if (bus.illegal_count !== CNT_W'(exp_cnt)) begin
      fails++; $display("FAIL count_after_table: got %0d expected %0d", bus.illegal_count, exp_cnt);
    end
  endtask

  task automatic test_stall_bge();
    drive(1'b1, 32'h003100B3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0020D463, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ex_vec !== EXP_ADD) begin
        fails++; $display("FAIL stall_hold_%0d: got %h expected %h", i, ex_vec, EXP_ADD);
      end
    end
    drive(1'b1, 32'h0020D463, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== mk(8'b1000_0000, 2'b01, 2'b00, 2'b00, 6'b001000)) begin
      fails++; $display("FAIL bge_after_stall: got %h expected %h", ex_vec,
                        mk(8'b1000_0000, 2'b01, 2'b00, 2'b00, 6'b001000));
    end
    tick();
  endtask

  task automatic test_illegal_flush();
    drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
    tick();
    exp_cnt = exp_cnt + 1;
    drive(1'b1, 32'h0000007F, 1'b0, 1'b1);
    checks++;
    if (ex_vec !== EXP_ILLEGAL) begin
      fails++; $display("FAIL illegal_out: got %h expected %h", ex_vec, EXP_ILLEGAL);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== 20'h0) begin
      fails++; $display("FAIL flushed_illegal: got %h expected 0", ex_vec);
    end
    checks++;
    if (bus.illegal_count !== CNT_W'(exp_cnt)) begin
      fails++; $display("FAIL flush_not_counted: got %0d expected %0d", bus.illegal_count, exp_cnt);
    end
  endtask

  task automatic test_flush_over_stall();
    drive(1'b1, 32'h003100B3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h003100B3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== 20'h0) begin
      fails++; $display("FAIL flush_over_stall: got %h expected 0", ex_vec);
    end
  endtask

  task automatic test_mul();
    logic [19:0] exp;
`ifdef RV32M_EN
    exp = mk(8'b1010_0000, 2'b11, 2'b00, 2'b00, 6'b0);
`else
    exp = EXP_ILLEGAL;
    exp_cnt = exp_cnt + 1;
`endif
    drive(1'b1, 32'h02208033, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== exp) begin
      fails++; $display("FAIL mul_decode: got %h expected %h", ex_vec, exp);
    end
    checks++;
    if (bus.illegal_count !== CNT_W'(exp_cnt)) begin
      fails++; $display("FAIL mul_count: got %0d expected %0d", bus.illegal_count, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    int n;
    n = (1 << CNT_W) - 1 - exp_cnt;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bus.illegal_count !== {CNT_W{1'b1}}) begin
      fails++; $display("FAIL count_reach_max: got %0d expected %0d", bus.illegal_count, (1 << CNT_W) - 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bus.illegal_count !== {CNT_W{1'b1}}) begin
      fails++; $display("FAIL count_saturate: got %0d expected %0d", bus.illegal_count, (1 << CNT_W) - 1);
    end
  endtask

  task automatic test_halt_flushed();
    drive(1'b1, 32'h02000073, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.dbg_state !== ST_RUN || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL flushed_halt_ignored: got state %0d ready %b expected state 0 ready 1",
                        bus.dbg_state, bus.in_ready);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 32'h02000073, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h003100B3, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL drain_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.dbg_state !== ST_DRAIN) begin
      fails++; $display("FAIL drain_state: got %0d expected %0d", bus.dbg_state, ST_DRAIN);
    end
    for (int e = 1; e <= DRAIN + 1; e++) begin
      checks++;
      if (bus.halt !== (e > DRAIN)) begin
        fails++; $display("FAIL halt_edge_%0d: got %b expected %b", e, bus.halt, (e > DRAIN));
      end
      if (e == 2) begin
        checks++;
        if (ex_vec !== 20'h0) begin
          fails++; $display("FAIL drain_bubble: got %h expected 0", ex_vec);
        end
      end
      if (e <= DRAIN) tick();
    end
    tick();
    checks++;
    if (bus.halt !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL halted_hold: got halt %b ready %b expected halt 1 ready 0", bus.halt, bus.in_ready);
    end
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.halt !== 1'b0 || bus.dbg_state !== ST_RUN || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_from_halt: got halt %b state %0d ready %b expected 0 0 1",
                        bus.halt, bus.dbg_state, bus.in_ready);
    end
    checks++;
    if (bus.illegal_count !== '0) begin
      fails++; $display("FAIL reset_count_clear: got %0d expected 0", bus.illegal_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h003100B3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000A103, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== EXP_ADD) begin
      fails++; $display("FAIL b2b_first: got %h expected %h", ex_vec, EXP_ADD);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ex_vec !== mk(8'b1011_1000, 2'b00, 2'b00, 2'b01, 6'b0)) begin
      fails++; $display("FAIL b2b_second: got %h expected %h", ex_vec,
                        mk(8'b1011_1000, 2'b00, 2'b00, 2'b01, 6'b0));
    end
    tick();
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    exp_cnt = 0;
    test_reset();
    test_decode_table();
    test_stall_bge();
    test_illegal_flush();
    test_mul();
    test_flush_over_stall();
    test_saturation();
    test_halt_flushed();
    test_halt();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
